// File: rtl/rv32_dmem_lsu.sv
// Data memory with a load/store front end: byte-lane masked stores, extended loads,
// misalignment/illegal-size flagging and an optional zero-fill sweep after reset.
module rv32_dmem_lsu #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 13,
    parameter int CLEAR_ON_RESET = 1,
    localparam int LANES         = DATA_W / 8,
    localparam int OFS_W         = $clog2(LANES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W+OFS_W-1:0] req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    init_done,
    output logic                    dbg_state
);
    // Handshake: a request is taken on any rising edge where req_valid && req_ready;
    // the response is presented for exactly one cycle, one cycle later, and cannot stall.
    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    localparam int     DEPTH     = 1 << ADDR_W;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_word;
    logic                r_valid, r_err, r_load_ok, r_uns;
    logic [1:0]          r_size;
    logic [OFS_W-1:0]    r_ofs;

    logic [ADDR_W-1:0]   w_index;
    logic [OFS_W-1:0]    w_ofs;
    logic [3:0]          w_ofs4, w_nbytes, w_amask;
    logic                w_size_ok, w_misal, w_legal, w_accept, w_store;
    logic [LANES-1:0]    w_be;
    logic [DATA_W-1:0]   w_wdata;

    assign w_index   = req_addr[ADDR_W+OFS_W-1:OFS_W];
    assign w_ofs     = req_addr[OFS_W-1:0];
    assign w_ofs4    = 4'(w_ofs);
    assign w_nbytes  = 4'd1 << req_size;
    assign w_amask   = w_nbytes - 4'd1;
    assign w_size_ok = (req_size != 2'd3) || (DATA_W == 64);
    assign w_misal   = |(w_ofs & w_amask[OFS_W-1:0]);
    assign w_legal   = w_size_ok && !w_misal;
    // Gating with reset keeps a request in the reset cycle from touching memory.
    assign w_accept  = req_valid && (r_state == S_RUN) && !reset;
    assign w_store   = w_accept && req_we && w_legal;

    assign req_ready = (r_state == S_RUN);
    assign init_done = (r_state == S_RUN);
    assign dbg_state = r_state;

    // Aligned accesses make (lane mod size) equal to the byte index within the field.
    always_comb begin
        w_be    = '0;
        w_wdata = '0;
        for (int l = 0; l < LANES; l++) begin
            w_be[l] = (4'(l) >= w_ofs4) && (4'(l) < (w_ofs4 + w_nbytes));
            w_wdata[l*8 +: 8] = req_wdata[(4'(l) & w_amask & 4'(LANES-1))*8 +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (&r_cnt) w_state_nxt = S_RUN;
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (r_state == S_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_store) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_be[l]) r_mem[w_index][l*8 +: 8] <= w_wdata[l*8 +: 8];
            end
        end
        r_word <= r_mem[w_index];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= RST_STATE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_load_ok <= 1'b0;
            r_uns     <= 1'b0;
            r_size    <= '0;
            r_ofs     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_accept;
            r_err     <= w_accept && !w_legal;
            r_load_ok <= w_accept && !req_we && w_legal;
            r_uns     <= req_unsigned;
            r_size    <= req_size;
            r_ofs     <= w_ofs;
        end
    end

    logic [DATA_W-1:0] w_shift, w_fmask, w_ext;
    logic [7:0]        w_fbits;
    logic              w_full, w_msb;

    // Field is shifted to bit 0; the top bit of the field mask locates its MSB.
    assign w_shift   = r_word >> {r_ofs, 3'b000};
    assign w_fbits   = 8'd8 << r_size;
    assign w_full    = (w_fbits == 8'(DATA_W));
    assign w_fmask   = w_full ? '1 : ((ONE << w_fbits) - ONE);
    assign w_msb     = |(w_shift & (w_fmask ^ (w_fmask >> 1)));
    assign w_ext     = (w_shift & w_fmask) | ((w_msb && !r_uns && !w_full) ? ~w_fmask : '0);

    assign rsp_valid = r_valid;
    assign rsp_err   = r_err;
    assign rsp_rdata = r_load_ok ? w_ext : '0;
endmodule

// File: tb/tb_rv32_dmem_lsu.sv
// Directed bench for rv32_dmem_lsu: 32-bit and 64-bit instances with clear sweep,
// plus a 32-bit instance without clear, checked against hand-computed values.
module tb_rv32_dmem_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_we, req_uns;
  logic [6:0]  req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        v32, v64, vnc;

  logic        rdy32, rv32, er32, id32, st32;
  logic [31:0] rd32;
  logic        rdy64, rv64, er64, id64, st64;
  logic [63:0] rd64;
  logic        rdync, rvnc, ernc, idnc, stnc;
  logic [31:0] rdnc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  rv32_dmem_lsu #(.DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(1)) dut32 (
    .clock(clk), .reset(reset), .req_valid(v32), .req_ready(rdy32), .req_we(req_we),
    .req_addr(req_addr[5:0]), .req_size(req_size), .req_unsigned(req_uns),
    .req_wdata(req_wdata[31:0]), .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_err(er32),
    .init_done(id32), .dbg_state(st32));

  rv32_dmem_lsu #(.DATA_W(64), .ADDR_W(4), .CLEAR_ON_RESET(1)) dut64 (
    .clock(clk), .reset(reset), .req_valid(v64), .req_ready(rdy64), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_uns),
    .req_wdata(req_wdata), .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_err(er64),
    .init_done(id64), .dbg_state(st64));

  rv32_dmem_lsu #(.DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(0)) dut_nc (
    .clock(clk), .reset(reset), .req_valid(vnc), .req_ready(rdync), .req_we(req_we),
    .req_addr(req_addr[5:0]), .req_size(req_size), .req_unsigned(req_uns),
    .req_wdata(req_wdata[31:0]), .rsp_valid(rvnc), .rsp_rdata(rdnc), .rsp_err(ernc),
    .init_done(idnc), .dbg_state(stnc));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // d: 0 = 32-bit instance, 1 = 64-bit instance. Response sampled one cycle after accept.
  task automatic do_req(input int d, input logic we, input logic [6:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err, input string tag);
    req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
    if (d == 0) v32 = 1'b1; else v64 = 1'b1;
    tick();
    v32 = 1'b0; v64 = 1'b0;
    if (d == 0) begin
      check_eq({tag, "_valid"}, {63'b0, rv32}, 64'd1);
      check_eq({tag, "_rdata"}, {32'b0, rd32}, exp_rd);
      check_eq({tag, "_err"},   {63'b0, er32}, {63'b0, exp_err});
    end else begin
      check_eq({tag, "_valid"}, {63'b0, rv64}, 64'd1);
      check_eq({tag, "_rdata"}, rd64, exp_rd);
      check_eq({tag, "_err"},   {63'b0, er64}, {63'b0, exp_err});
    end
  endtask

  logic        s_we   [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
  logic [6:0]  s_addr [8] = '{7'h00, 7'h0C, 7'h0C, 7'h09, 7'h08, 7'h08, 7'h0C, 7'h00};
  logic [1:0]  s_size [8] = '{2, 2, 2, 0, 2, 2, 2, 2};
  logic        s_uns  [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
  logic [63:0] s_exp  [4] = '{64'h80FF7F01, 64'h0, 64'h55667788, 64'hAA};

  initial begin
    int n;
    int pulses;
    reset = 1'b1; v32 = 1'b0; v64 = 1'b0; vnc = 1'b0;
    req_we = 1'b0; req_addr = '0; req_size = 2'd2; req_uns = 1'b0; req_wdata = '0;
    tick(); tick();

    check_eq("rst_ready",     {63'b0, rdy32}, 64'd0);
    check_eq("rst_rsp_valid", {63'b0, rv32},  64'd0);
    check_eq("rst_rdata",     {32'b0, rd32},  64'd0);
    check_eq("rst_err",       {63'b0, er32},  64'd0);
    check_eq("rst_init_done", {63'b0, id32},  64'd0);
    check_eq("rst_state",     {63'b0, st32},  64'd0);
    check_eq("nc_init_done",  {63'b0, idnc},  64'd1);

    reset = 1'b0;
    check_eq("nc_ready_cycle0", {63'b0, rdync}, 64'd1);
    n = 0;
    while (!rdy32 && n < 100) begin
      tick();
      n++;
    end
    check_eq("init_len", 64'(n), 64'd16);
    check_eq("init_done_up", {63'b0, id32}, 64'd1);

    for (int a = 0; a < 16; a++)
      do_req(0, 1'b0, 7'(a * 4), 2'd2, 1'b0, 64'h0, 64'h0, 1'b0, $sformatf("clr_w%0d", a));
    do_req(1, 1'b0, 7'h38, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0, "clr64_w7");

    do_req(0, 1'b1, 7'h08, 2'd2, 1'b0, 64'h11223344, 64'h0, 1'b0, "sw_8");
    do_req(0, 1'b1, 7'h09, 2'd0, 1'b0, 64'hAA, 64'h0, 1'b0, "sb_9");
    do_req(0, 1'b0, 7'h08, 2'd2, 1'b0, 64'h0, 64'h1122AA44, 1'b0, "lw_8");
    tick();
    check_eq("idle_valid", {63'b0, rv32}, 64'd0);

    do_req(0, 1'b1, 7'h00, 2'd2, 1'b0, 64'h80FF7F01, 64'h0, 1'b0, "sw_0");
    do_req(0, 1'b0, 7'h01, 2'd0, 1'b0, 64'h0, 64'h0000007F, 1'b0, "lb_1");
    do_req(0, 1'b0, 7'h02, 2'd0, 1'b0, 64'h0, 64'hFFFFFFFF, 1'b0, "lb_2");
    do_req(0, 1'b0, 7'h03, 2'd0, 1'b1, 64'h0, 64'h00000080, 1'b0, "lbu_3");
    do_req(0, 1'b0, 7'h02, 2'd1, 1'b0, 64'h0, 64'hFFFF80FF, 1'b0, "lh_2");
    do_req(0, 1'b0, 7'h02, 2'd1, 1'b1, 64'h0, 64'h000080FF, 1'b0, "lhu_2");

    do_req(0, 1'b0, 7'h03, 2'd1, 1'b0, 64'h0, 64'h0, 1'b1, "lh_3_mis");
    do_req(0, 1'b1, 7'h06, 2'd2, 1'b0, 64'h12345678, 64'h0, 1'b1, "sw_6_mis");
    do_req(0, 1'b1, 7'h00, 2'd3, 1'b0, 64'hDEADBEEF, 64'h0, 1'b1, "sd_32_ill");
    do_req(0, 1'b0, 7'h00, 2'd3, 1'b0, 64'h0, 64'h0, 1'b1, "ld_32_ill");
    do_req(0, 1'b0, 7'h04, 2'd2, 1'b0, 64'h0, 64'h0, 1'b0, "lw_4_unch");
    do_req(0, 1'b0, 7'h00, 2'd2, 1'b0, 64'h0, 64'h80FF7F01, 1'b0, "lw_0_unch");

    do_req(1, 1'b1, 7'h10, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b0, "sd_10");
    do_req(1, 1'b0, 7'h14, 2'd2, 1'b0, 64'h0, 64'h0000000001234567, 1'b0, "lw64_14");
    do_req(1, 1'b0, 7'h10, 2'd2, 1'b0, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, "lw64_10");
    do_req(1, 1'b0, 7'h10, 2'd2, 1'b1, 64'h0, 64'h0000000089ABCDEF, 1'b0, "lwu64_10");
    do_req(1, 1'b0, 7'h10, 2'd3, 1'b0, 64'h0, 64'h0123456789ABCDEF, 1'b0, "ld64_10");
    do_req(1, 1'b0, 7'h16, 2'd1, 1'b1, 64'h0, 64'h0000000000000123, 1'b0, "lhu64_16");
    do_req(1, 1'b0, 7'h12, 2'd2, 1'b0, 64'h0, 64'h0, 1'b1, "lw64_12_mis");

    // Back-to-back stream with a one-cycle reset right after the 4th acceptance.
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      req_we = s_we[k]; req_addr = s_addr[k]; req_size = s_size[k];
      req_uns = s_uns[k]; req_wdata = 64'h55667788;
      v32 = 1'b1;
      if (k == 4) reset = 1'b1;
      if (k < 4) exp_q.push_back(s_exp[k]);
      tick();
      reset = 1'b0;
      if (rv32) begin
        pulses++;
        if (exp_q.size() > 0) check_eq($sformatf("stream_rd%0d", k), {32'b0, rd32}, exp_q.pop_front());
      end
    end
    v32 = 1'b0;
    repeat (3) begin
      tick();
      if (rv32) pulses++;
    end
    check_eq("stream_pulses", 64'(pulses), 64'd4);
    check_eq("stream_q_empty", 64'(exp_q.size()), 64'd0);

    n = 0;
    while (!rdy32 && n < 100) begin
      tick();
      n++;
    end
    check_eq("reinit_len", 64'(n), 64'd10);
    do_req(0, 1'b0, 7'h08, 2'd2, 1'b0, 64'h0, 64'h0, 1'b0, "post_clr_8");
    do_req(0, 1'b0, 7'h0C, 2'd2, 1'b0, 64'h0, 64'h0, 1'b0, "post_clr_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
